// File: rtl/mem_stream_reader_pkg.sv
// Shared definitions for the memory read-back streamer: width defaults and
// the controller state encoding (visible by name in waveforms).
package mem_stream_reader_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int REG_WIDTH_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD,
    ST_DONE
  } mem_rd_state_t;

endpackage

// File: rtl/mem_stream_reader_if.sv
// Shared memory-port bus plus the outgoing byte stream of the reader.
// master = the reader, slave = arbiter/memory/sink side.
interface mem_stream_reader_if
  import mem_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = REG_WIDTH_DEF
) ();

  logic                  bus_req;
  logic                  bus_gnt;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_r_w_n;
  logic                  mem_en;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output bus_req, mem_addr, mem_r_w_n, mem_en, out_data, out_valid,
    input  bus_gnt, mem_din, out_ready
  );

  modport slave (
    input  bus_req, mem_addr, mem_r_w_n, mem_en, out_data, out_valid,
    output bus_gnt, mem_din, out_ready
  );

endinterface

// File: rtl/mem_rd_lat_pipe.sv
// Delays the read strobe by RD_LAT cycles so the controller knows exactly
// which cycle carries valid memory data.
module mem_rd_lat_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic issue,
  output logic capture
);

  logic stage_reg [RD_LAT];

  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) stage_reg[gi] <= 1'b0;
          else          stage_reg[gi] <= issue;
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) stage_reg[gi] <= 1'b0;
          else          stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign capture = stage_reg[RD_LAT-1];

endmodule

// File: rtl/mem_stream_reader.sv
// Bus initiator that reads a contiguous memory range one byte at a time
// through a shared, arbitrated port and streams the bytes out valid/ready.
module mem_stream_reader
  import mem_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = REG_WIDTH_DEF,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  mem_stream_reader_if.master   bus
);

  mem_rd_state_t         state_reg;
  logic [ADDR_WIDTH-1:0] cur_addr_reg;
  logic [ADDR_WIDTH:0]   remaining_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  bus_req_reg;
  logic                  mem_en_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  capture_en;

  mem_rd_lat_pipe #(.RD_LAT(RD_LAT)) u_lat_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .issue   (mem_en_reg),
    .capture (capture_en)
  );

  // The grant is qualified on the way into ISSUE, so the registered strobe
  // only ever fires in the cycle after the grant was sampled high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      bus_req_reg   <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      done_reg   <= 1'b0;
      mem_en_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            cur_addr_reg  <= base_addr;
            remaining_reg <= length;
            if (length == '0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg   <= ST_REQ;
              busy_reg    <= 1'b1;
              bus_req_reg <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (bus.bus_gnt) begin
            state_reg    <= ST_ISSUE;
            mem_en_reg   <= 1'b1;
            mem_addr_reg <= cur_addr_reg;
            cur_addr_reg <= cur_addr_reg + 1'b1;
          end
        end
        ST_ISSUE: state_reg <= ST_WAIT;
        ST_WAIT: begin
          if (capture_en) begin
            out_data_reg  <= bus.mem_din;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            remaining_reg <= remaining_reg - 1'b1;
            if (remaining_reg == (ADDR_WIDTH+1)'(1)) begin
              state_reg   <= ST_DONE;
              done_reg    <= 1'b1;
              busy_reg    <= 1'b0;
              bus_req_reg <= 1'b0;
            end else if (bus.bus_gnt) begin
              state_reg    <= ST_ISSUE;
              mem_en_reg   <= 1'b1;
              mem_addr_reg <= cur_addr_reg;
              cur_addr_reg <= cur_addr_reg + 1'b1;
            end else begin
              state_reg <= ST_REQ;
            end
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign bus.bus_req   = bus_req_reg;
  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_r_w_n = 1'b1;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench: two readers (RD_LAT 1 and 3) share stimulus; expected
// addresses and bytes are queued per reader and checked by a monitor.
`ifndef SEED
`define SEED 32'd1
`endif

module tb_mem_stream_reader;
  import mem_stream_reader_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          bus_gnt;
  logic          out_ready;
  logic          rand_ready;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  mem [65536];
  logic [15:0] exp_addr_q [2][$];
  logic [7:0]  exp_data_q [2][$];

  logic        busy_w [2], done_w [2], bus_req_w [2], mem_en_w [2], rw_w [2], valid_w [2];
  logic [15:0] addr_w [2];
  logic [7:0]  data_w [2];

  int   checks = 0, failures = 0;
  int   done_cnt [2], hs_cnt [2], done_base [2], hs_base [2];
  int   first_valid_cyc [2];
  bit   armed [2];
  bit   hold_prev [2], valid_prev [2];
  logic [7:0] data_prev [2];
  logic gnt_prev;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 1 : 3;
      mem_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();
      mem_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(LAT)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy_w[gi]), .done(done_w[gi]), .bus(bus_if.master)
      );
      logic [7:0] rd_pipe [LAT];
      always @(posedge clk) begin
        rd_pipe[0] <= bus_if.mem_en ? mem[bus_if.mem_addr] : 8'h00;
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
      end
      assign bus_if.mem_din   = rd_pipe[LAT-1];
      assign bus_if.bus_gnt   = bus_gnt;
      assign bus_if.out_ready = out_ready;
      assign bus_req_w[gi] = bus_if.bus_req;
      assign mem_en_w[gi]  = bus_if.mem_en;
      assign rw_w[gi]      = bus_if.mem_r_w_n;
      assign valid_w[gi]   = bus_if.out_valid;
      assign addr_w[gi]    = bus_if.mem_addr;
      assign data_w[gi]    = bus_if.out_data;
    end
  endgenerate

  function automatic logic [7:0] model_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic void chk(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (reset_n) begin
          if (mem_en_w[i]) begin
            chk($sformatf("u%0d_r_w_n", i), rw_w[i], 1);
            chk($sformatf("u%0d_issue_grant", i), gnt_prev, 1);
            if (exp_addr_q[i].size() == 0) begin
              checks++; failures++;
              $display("FAIL u%0d_unexpected_issue actual=%04h required=none", i, addr_w[i]);
            end else begin
              chk($sformatf("u%0d_addr", i), addr_w[i], exp_addr_q[i].pop_front());
            end
          end
          if (armed[i] && valid_w[i] && !valid_prev[i]) begin
            first_valid_cyc[i] = cyc;
            armed[i] = 1'b0;
          end
          if (hold_prev[i]) begin
            chk($sformatf("u%0d_stall_valid", i), valid_w[i], 1);
            chk($sformatf("u%0d_stall_data", i), data_w[i], data_prev[i]);
          end
          if (valid_w[i] && out_ready) begin
            if (exp_data_q[i].size() == 0) begin
              checks++; failures++;
              $display("FAIL u%0d_unexpected_byte actual=%02h required=none", i, data_w[i]);
            end else begin
              chk($sformatf("u%0d_data", i), data_w[i], exp_data_q[i].pop_front());
            end
            hs_cnt[i]++;
          end
          if (done_w[i]) done_cnt[i]++;
        end
        hold_prev[i]  = reset_n && valid_w[i] && !out_ready;
        valid_prev[i] = valid_w[i];
        data_prev[i]  = data_w[i];
      end
      gnt_prev = bus_gnt;
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic push_range(input logic [15:0] b, input int n);
    logic [15:0] a;
    for (int k = 0; k < n; k++) begin
      a = b + 16'(k);
      for (int i = 0; i < 2; i++) begin
        exp_addr_q[i].push_back(a);
        exp_data_q[i].push_back(model_byte(a));
      end
    end
  endtask

  task automatic start_dump(input logic [15:0] b, input logic [16:0] l, output int c);
    for (int i = 0; i < 2; i++) begin
      done_base[i] = done_cnt[i];
      hs_base[i]   = hs_cnt[i];
      armed[i]     = 1'b1;
    end
    @(posedge clk); #1;
    base_addr = b; length = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    c = cyc;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_busy_n1", i), busy_w[i], (l != 0) ? 1 : 0);
      chk($sformatf("u%0d_bus_req_n1", i), bus_req_w[i], (l != 0) ? 1 : 0);
      chk($sformatf("u%0d_done_n1", i), done_w[i], (l == 0) ? 1 : 0);
    end
  endtask

  task automatic wait_done(input int nbytes);
    int t = 0;
    while ((done_cnt[0] == done_base[0] || done_cnt[1] == done_base[1]) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_done_pulses", i), done_cnt[i] - done_base[i], 1);
      chk($sformatf("u%0d_handshakes", i), hs_cnt[i] - hs_base[i], nbytes);
      chk($sformatf("u%0d_bytes_left", i), exp_data_q[i].size(), 0);
      chk($sformatf("u%0d_busy_after", i), busy_w[i], 0);
    end
  endtask

  task automatic check_reset_vals();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_rst_busy", i), busy_w[i], 0);
      chk($sformatf("u%0d_rst_done", i), done_w[i], 0);
      chk($sformatf("u%0d_rst_bus_req", i), bus_req_w[i], 0);
      chk($sformatf("u%0d_rst_mem_en", i), mem_en_w[i], 0);
      chk($sformatf("u%0d_rst_mem_addr", i), addr_w[i], 0);
      chk($sformatf("u%0d_rst_r_w_n", i), rw_w[i], 1);
      chk($sformatf("u%0d_rst_out_valid", i), valid_w[i], 0);
      chk($sformatf("u%0d_rst_out_data", i), data_w[i], 0);
    end
  endtask

  initial begin
    int c, t, seen;
    logic [7:0] prog [4];
    prog[0] = 8'hA9; prog[1] = 8'h01; prog[2] = 8'h8D; prog[3] = 8'h00;
    for (int a = 0; a < 65536; a++) mem[a] = model_byte(16'(a));
    for (int k = 0; k < 4; k++) mem[16'h0200 + k] = prog[k];
    void'($urandom(`SEED));
    reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    bus_gnt = 1'b0; out_ready = 1'b0; rand_ready = 1'b0; gnt_prev = 1'b0;
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0; hs_cnt[i] = 0; armed[i] = 1'b0;
      hold_prev[i] = 1'b0; valid_prev[i] = 1'b0; data_prev[i] = '0;
    end
    fork
      monitor();
      ready_driver();
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    reset_n = 1'b1;
    bus_gnt = 1'b1; out_ready = 1'b1;

    // Basic dump with hand-written program bytes and first-byte latency.
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 2; i++) begin
        exp_addr_q[i].push_back(16'h0200 + 16'(k));
        exp_data_q[i].push_back(prog[k]);
      end
    start_dump(16'h0200, 17'd4, c);
    wait_done(4);
    chk("u0_first_valid_latency", first_valid_cyc[0] - c, 2 + 1);
    chk("u1_first_valid_latency", first_valid_cyc[1] - c, 2 + 3);

    // Backpressure.
    push_range(16'h1000, 10);
    rand_ready = 1'b1;
    start_dump(16'h1000, 17'd10, c);
    wait_done(10);
    rand_ready = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;

    // Grant loss for 5 cycles in the middle of a length-8 dump.
    push_range(16'h2000, 8);
    start_dump(16'h2000, 17'd8, c);
    t = 0;
    while (hs_cnt[0] - hs_base[0] < 3 && t < 500) begin @(negedge clk); t++; end
    @(posedge clk); #1 bus_gnt = 1'b0;
    repeat (5) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (busy_w[i]) chk($sformatf("u%0d_req_no_gnt", i), bus_req_w[i], 1);
    end
    @(posedge clk); #1 bus_gnt = 1'b1;
    wait_done(8);

    // Address wrap and zero length.
    push_range(16'hFFFE, 4);
    start_dump(16'hFFFE, 17'd4, c);
    wait_done(4);
    start_dump(16'h0123, 17'd0, c);
    wait_done(0);

    // start asserted during reader 0's done cycle must be ignored.
    push_range(16'h3000, 2);
    start_dump(16'h3000, 17'd2, c);
    seen = 0; t = 0;
    while (seen < 2 && t < 500) begin
      @(negedge clk);
      if (valid_w[0] && out_ready) seen++;
      t++;
    end
    @(posedge clk); #1;
    base_addr = 16'h4000; length = 17'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(2);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_ignored_start_done", i), done_cnt[i] - done_base[i], 1);
      chk($sformatf("u%0d_ignored_start_busy", i), busy_w[i], 0);
    end

    // Reset during WAIT of byte 3, then a fresh dump.
    push_range(16'h5000, 6);
    start_dump(16'h5000, 17'd6, c);
    t = 0;
    while (!(hs_cnt[0] - hs_base[0] >= 2 && mem_en_w[0]) && t < 500) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    for (int i = 0; i < 2; i++) begin
      exp_addr_q[i].delete();
      exp_data_q[i].delete();
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);
    push_range(16'h6000, 3);
    start_dump(16'h6000, 17'd3, c);
    wait_done(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stream_reader.md
# mem_stream_reader

Bus initiator that reads a contiguous range of the 6502-side memory and streams the bytes out over a valid/ready interface. It is the read-back counterpart to the firmware loading path, which fills memory. It dumps memory contents for self-checking benches and, later, for the debug UART path. It shares the memory port with the CPU through an external arbiter: it requests the bus, waits for a grant, and issues one read at a time.

## Interface
- `ADDR_WIDTH`, default `` `ADDR_WIDTH `` (16): memory address width.
- `DATA_WIDTH`, default `` `REG_WIDTH `` (8): memory data width.
- `RD_LAT`, default 1: number of cycles from the issue cycle to the cycle in which `mem_din` is valid. Legal range is 1–4.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock. One clock domain.
- `reset_n`, in, 1: reset, asynchronous assert, active-low.
- `start`, in, 1: start a dump. Sampled only in IDLE.
- `base_addr`, in, ADDR_WIDTH: first address. Captured when `start` is accepted.
- `length`, in, ADDR_WIDTH+1: byte count. Captured when `start` is accepted. 0 is legal; 2^ADDR_WIDTH is the maximum.
- `busy`, out, 1: high from the cycle after `start` is accepted until `done`.
- `done`, out, 1: one-cycle pulse at the end of a dump.
- `bus_req`, out, 1: bus request to the arbiter.
- `bus_gnt`, in, 1: bus grant from the arbiter.
- `mem_addr`, out, ADDR_WIDTH: read address.
- `mem_r_w_n`, out, 1: always 1. This block never writes.
- `mem_en`, out, 1: read strobe. High for exactly one cycle per byte.
- `mem_din`, in, DATA_WIDTH: read data from memory.
- `out_data`, out, DATA_WIDTH: streamed byte.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: the sink accepts the byte.

## Operation
**States:** IDLE, REQ, ISSUE, WAIT, HOLD, DONE.

**IDLE**
- If `start` is high: capture `cur_addr <= base_addr` and `remaining <= length`.
- Next state is DONE if `length == 0`, otherwise REQ.
- `start` is ignored in every other state.

**REQ**
- `bus_req` = 1.
- Go to ISSUE in the first cycle `bus_gnt` is sampled high.

**ISSUE**
- Requires `bus_gnt` = 1. If `bus_gnt` has dropped, return to REQ without issuing.
- Drive `mem_en` = 1 and `mem_addr` = `cur_addr` for one cycle.
- Set `cur_addr <= cur_addr + 1`, modulo 2^ADDR_WIDTH (0xFFFF wraps to 0x0000).
- Go to WAIT.

**WAIT**
- Count RD_LAT cycles, capturing `mem_din` into `out_data` on the last one.
- The read completes even if `bus_gnt` drops meanwhile.
- Go to HOLD with `out_valid` = 1.

**HOLD**
- Hold `out_data` and `out_valid` stable until `out_valid && out_ready`.
- On that handshake, decrement `remaining`. Then:
  - if `remaining` was 1: go to DONE;
  - else if `bus_gnt` is high: go to ISSUE;
  - else: go to REQ.

**DONE**
- `done` = 1 for one cycle, then return to IDLE.

**Bus request**
- `bus_req` is high in REQ, ISSUE, WAIT and HOLD.
- It is low in IDLE and DONE.

**Reset**
- An asserted `reset_n` aborts any dump immediately and returns the block to IDLE.
- No partial byte is presented afterward.

## Timing
**Reset values:** `busy` 0, `done` 0, `bus_req` 0, `mem_en` 0, `mem_addr` 0, `mem_r_w_n` 1, `out_valid` 0, `out_data` 0.

All outputs are registered. The table-free sequence below assumes `bus_gnt` is already high:

| Cycle | Event |
|---|---|
| n | `start` accepted |
| n+1 | REQ, `busy` = 1, `bus_req` = 1 |
| n+2 | ISSUE |
| n+2+RD_LAT | capture |
| n+3+RD_LAT | `out_valid` = 1 |

**Throughput:** one byte per RD_LAT + 2 cycles, provided `out_ready` is held high and the grant is held.

**Length 0:** `start` at cycle n gives `done` at n+1. `busy` stays low and the bus is never requested.

**Completion:** `done` fires the cycle after the final handshake. `busy` and `bus_req` fall in that same cycle.

**Wrap-around:** with `base_addr` = 0xFFFE and `length` = 4, the addresses read are FFFE, FFFF, 0000, 0001.

**Edge cases:**
- `start` asserted in the same cycle as `done`: ignored, because the block is not yet in IDLE.
- `out_ready` high before `out_valid`: has no effect.

## Structure
- The shared package `PKG/pkg.v` holds:
  - the `` `ADDR_WIDTH `` and `` `REG_WIDTH `` defaults;
  - a `mem_rd_state_t` enum for the six states, so that benches can decode state in waveforms.
- One sub-module, `mem_rd_lat_pipe`:
  - an RD_LAT-deep shift register of the issue strobe;
  - produces the capture enable;
  - reset to all zeros.
- Everything else lives in `mem_stream_reader`.

## Test plan
- **Basic dump:** preload 0x0200–0x0203 with 0xA9 0x01 0x8D 0x00. Hold `bus_gnt` = 1 and `out_ready` = 1, then `start` with base 0x0200 and length 4. Expect:
  - exactly 4 handshakes carrying A9, 01, 8D, 00, in that order;
  - a single `done` pulse;
  - `mem_r_w_n` never low.
- **Backpressure:** toggle `out_ready` randomly with seed `` `SEED ``. Expect `out_data` to stay stable while `out_valid && !out_ready`, and no bytes lost or duplicated.
- **Grant loss:** deassert `bus_gnt` for 5 cycles in the middle of a length-8 dump. Expect:
  - `mem_en` stays low while the grant is low;
  - `bus_req` stays high;
  - all 8 bytes are delivered correctly.
- **Wrap and length edge cases:**
  - base 0xFFFE, length 4: addresses FFFE, FFFF, 0000, 0001.
  - length 0: `done` at n+1, no `bus_req`, no `mem_en`.
- **Reset mid-operation:** pull `reset_n` low during WAIT of byte 3. Expect all outputs at their reset values asynchronously. A new `start` after reset re-dumps from its own `base_addr` correctly.
- **RD_LAT = 3 build:** expect the capture 3 cycles after ISSUE and data matching the memory model byte-for-byte.
